// File: rtl/dma_burst_mem_responder.sv
// Word-addressed scratch RAM answering the DMA engine's burst read and burst write
// channels, with a debug port for preload and inspection.
module dma_burst_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW     = 10,
    parameter int RD_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [31:0]           rd_req_addr,
    input  logic [4:0]            rd_req_len,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    output logic [DATA_WIDTH-1:0] rd_rdata,
    output logic                  rd_valid,
    output logic                  rd_last,
    input  logic                  rd_ready,

    input  logic [31:0]           wr_req_addr,
    input  logic [4:0]            wr_req_len,
    input  logic                  wr_req_valid,
    output logic                  wr_req_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    input  logic                  wr_last,
    output logic                  wr_ready,
    output logic                  wr_err,

    input  logic                  dbg_wen,
    input  logic [MEM_AW-1:0]     dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic [DATA_WIDTH-1:0] dbg_rdata
);

    // Handshakes: a request, beat or data word transfers on a rising clk edge where
    // its valid and ready are both high; ready never depends combinationally on valid.

    localparam int         DEPTH     = 1 << MEM_AW;
    localparam logic [3:0] WAIT_LAST = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BEAT} rd_state_t;
    typedef enum logic       {W_IDLE, W_DATA}         wr_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    rd_state_t         r_state;
    logic [MEM_AW-1:0] rd_ptr;
    logic [4:0]        rd_cnt;
    logic [3:0]        wait_cnt;

    wr_state_t         w_state;
    logic [MEM_AW-1:0] wr_ptr;
    logic [4:0]        wr_cnt;
    logic              wr_beat;

    logic              unused_addr_bits;
    assign unused_addr_bits = ^{rd_req_addr[31:MEM_AW+2], rd_req_addr[1:0],
                                wr_req_addr[31:MEM_AW+2], wr_req_addr[1:0]};

    // ---------------- read channel ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= R_IDLE;
            rd_ptr       <= '0;
            rd_cnt       <= '0;
            wait_cnt     <= '0;
            rd_req_ready <= 1'b1;
            rd_valid     <= 1'b0;
            rd_last      <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    wait_cnt <= '0;
                    if (rd_req_valid) begin
                        rd_ptr       <= rd_req_addr[MEM_AW+1:2];
                        rd_cnt       <= rd_req_len;
                        rd_req_ready <= 1'b0;
                        if (RD_LATENCY > 0) begin
                            r_state <= R_WAIT;
                        end else begin
                            r_state  <= R_BEAT;
                            rd_valid <= 1'b1;
                            rd_last  <= (rd_req_len == 5'd0);
                        end
                    end
                end
                R_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        r_state  <= R_BEAT;
                        rd_valid <= 1'b1;
                        rd_last  <= (rd_cnt == 5'd0);
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                R_BEAT: begin
                    if (rd_ready) begin
                        if (rd_last) begin
                            r_state      <= R_IDLE;
                            rd_valid     <= 1'b0;
                            rd_last      <= 1'b0;
                            rd_req_ready <= 1'b1;
                        end else begin
                            rd_ptr  <= rd_ptr + MEM_AW'(1);
                            rd_cnt  <= rd_cnt - 5'd1;
                            rd_last <= (rd_cnt == 5'd1);
                        end
                    end
                end
                default: begin
                    r_state      <= R_IDLE;
                    rd_valid     <= 1'b0;
                    rd_last      <= 1'b0;
                    rd_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign rd_rdata = rd_valid ? mem[rd_ptr] : '0;

    // ---------------- write channel ----------------
    // A burst ends on whichever comes first: the master's last flag or the
    // requested beat count; any disagreement between the two is latched in wr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state      <= W_IDLE;
            wr_ptr       <= '0;
            wr_cnt       <= '0;
            wr_req_ready <= 1'b1;
            wr_ready     <= 1'b0;
            wr_err       <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (wr_req_valid) begin
                        w_state      <= W_DATA;
                        wr_ptr       <= wr_req_addr[MEM_AW+1:2];
                        wr_cnt       <= wr_req_len;
                        wr_req_ready <= 1'b0;
                        wr_ready     <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (wr_valid) begin
                        wr_ptr <= wr_ptr + MEM_AW'(1);
                        wr_cnt <= wr_cnt - 5'd1;
                        if (wr_last != (wr_cnt == 5'd0)) begin
                            wr_err <= 1'b1;
                        end
                        if (wr_last || (wr_cnt == 5'd0)) begin
                            w_state      <= W_IDLE;
                            wr_ready     <= 1'b0;
                            wr_req_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    w_state      <= W_IDLE;
                    wr_ready     <= 1'b0;
                    wr_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign wr_beat = wr_ready && wr_valid && !rst;

    // ---------------- RAM ----------------
    // Write channel is assigned last so it wins a same-word collision with debug.
    always_ff @(posedge clk) begin
        if (dbg_wen) begin
            mem[dbg_addr] <= dbg_wdata;
        end
        if (wr_beat) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign dbg_rdata = mem[dbg_addr];

endmodule

// File: tb/tb_dma_burst_mem_responder.sv
// Randomized scoreboard bench for dma_burst_mem_responder: a word-array memory model
// predicts read beats and RAM contents; a negedge monitor checks every read beat.
module tb_dma_burst_mem_responder;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int TMO   = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT (RD_LATENCY = 0) ----------------
  logic [31:0]   rd_req_addr, wr_req_addr;
  logic [4:0]    rd_req_len, wr_req_len;
  logic          rd_req_valid, rd_req_ready, rd_valid, rd_last, rd_ready;
  logic [DW-1:0] rd_rdata, wr_data, dbg_wdata, dbg_rdata;
  logic          wr_req_valid, wr_req_ready, wr_valid, wr_last, wr_ready, wr_err;
  logic          dbg_wen;
  logic [AW-1:0] dbg_addr;
  logic          dir_ready, rnd_ready, rdy_rand;

  assign rd_ready = rdy_rand ? rnd_ready : dir_ready;

  dma_burst_mem_responder #(.DATA_WIDTH(DW), .MEM_AW(AW), .RD_LATENCY(0)) dut (
    .clk(clk), .rst(rst),
    .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len), .rd_req_valid(rd_req_valid),
    .rd_req_ready(rd_req_ready), .rd_rdata(rd_rdata), .rd_valid(rd_valid),
    .rd_last(rd_last), .rd_ready(rd_ready),
    .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len), .wr_req_valid(wr_req_valid),
    .wr_req_ready(wr_req_ready), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_last(wr_last), .wr_ready(wr_ready), .wr_err(wr_err),
    .dbg_wen(dbg_wen), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
  );

  // ---------------- second DUT (RD_LATENCY = 3) ----------------
  logic [31:0]   l_rd_req_addr, l_wr_req_addr;
  logic [4:0]    l_rd_req_len, l_wr_req_len;
  logic          l_rd_req_valid, l_rd_req_ready, l_rd_valid, l_rd_last, l_rd_ready;
  logic [DW-1:0] l_rd_rdata, l_wr_data, l_dbg_wdata, l_dbg_rdata;
  logic          l_wr_req_valid, l_wr_req_ready, l_wr_valid, l_wr_last, l_wr_ready, l_wr_err;
  logic          l_dbg_wen;
  logic [AW-1:0] l_dbg_addr;

  dma_burst_mem_responder #(.DATA_WIDTH(DW), .MEM_AW(AW), .RD_LATENCY(3)) dut_lat (
    .clk(clk), .rst(rst),
    .rd_req_addr(l_rd_req_addr), .rd_req_len(l_rd_req_len), .rd_req_valid(l_rd_req_valid),
    .rd_req_ready(l_rd_req_ready), .rd_rdata(l_rd_rdata), .rd_valid(l_rd_valid),
    .rd_last(l_rd_last), .rd_ready(l_rd_ready),
    .wr_req_addr(l_wr_req_addr), .wr_req_len(l_wr_req_len), .wr_req_valid(l_wr_req_valid),
    .wr_req_ready(l_wr_req_ready), .wr_data(l_wr_data), .wr_valid(l_wr_valid),
    .wr_last(l_wr_last), .wr_ready(l_wr_ready), .wr_err(l_wr_err),
    .dbg_wen(l_dbg_wen), .dbg_addr(l_dbg_addr), .dbg_wdata(l_dbg_wdata),
    .dbg_rdata(l_dbg_rdata)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW:0]   exp_q[$];        // {last, data} per expected read beat
  bit            err_model;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor ----------------
  logic        prev_stall;
  logic [DW:0] prev_beat;
  logic [DW:0] mon_exp;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("rd_stall_valid", rd_valid, 1);
        check("rd_stall_hold", {rd_last, rd_rdata}, prev_beat);
      end
      if (!rd_valid) begin
        check("rd_idle_outputs", {rd_last, rd_rdata}, '0);
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_beat: unexpected beat %h, none expected (t=%0t)",
                   {rd_last, rd_rdata}, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rd_beat", {rd_last, rd_rdata}, mon_exp);
        end
      end
      prev_stall = rd_valid && !rd_ready;
      prev_beat  = {rd_last, rd_rdata};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic dbg_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    dbg_wen = 1'b1; dbg_addr = a; dbg_wdata = d;
    @(posedge clk); #1;
    dbg_wen = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [4:0] len);
    logic [AW-1:0] p;
    bit ok;
    @(posedge clk); #1;
    rd_req_addr = addr; rd_req_len = len; rd_req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < TMO && !ok; i++) begin
      @(negedge clk); ok = rd_req_ready;
      @(posedge clk); #1;
    end
    rd_req_valid = 1'b0;
    check("rd_req_handshake", ok, 1);
    if (ok) begin
      p = addr[AW+1:2];
      for (int k = 0; k <= int'(len); k++) begin
        exp_q.push_back({(k == int'(len)), model_mem[p]});
        p = p + AW'(1);
      end
    end
  endtask

  task automatic wait_read_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < TMO * 4 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (exp_q.size() == 0);
    end
    check("rd_drain", ok, 1);
    @(negedge clk);
    check("rd_req_ready_after_burst", {rd_req_ready, rd_valid}, 2'b10);
  endtask

  task automatic wr_request(input logic [31:0] addr, input logic [4:0] len);
    bit ok;
    @(posedge clk); #1;
    wr_req_addr = addr; wr_req_len = len; wr_req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < TMO && !ok; i++) begin
      @(negedge clk); ok = wr_req_ready;
      @(posedge clk); #1;
    end
    wr_req_valid = 1'b0;
    check("wr_req_handshake", ok, 1);
  endtask

  // last_at: beat index carrying wr_last (-1 for none); the model decides the end.
  task automatic do_write(input logic [31:0] addr, input logic [4:0] len, input int last_at,
                          input bit seq_data, input logic [DW-1:0] base, input int max_bubble);
    logic [AW-1:0] p;
    logic [DW-1:0] d;
    int  cnt, k;
    bit  done, ok, lst;
    wr_request(addr, len);
    @(negedge clk);
    check("wr_ready_after_req", {wr_ready, wr_req_ready}, 2'b10);
    p = addr[AW+1:2]; cnt = int'(len); k = 0; done = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      repeat ($urandom_range(0, max_bubble)) begin
        wr_valid = 1'b0;
        @(posedge clk); #1;
      end
      d   = seq_data ? base + DW'(k) : $urandom;
      lst = (k == last_at);
      wr_valid = 1'b1; wr_data = d; wr_last = lst;
      ok = 1'b0;
      for (int i = 0; i < TMO && !ok; i++) begin
        @(negedge clk); ok = wr_ready;
        if (!ok) begin
          @(posedge clk); #1;
        end
      end
      if (!ok) begin
        check("wr_beat_handshake", ok, 1);
        done = 1'b1;
      end else begin
        model_mem[p] = d;
        if (lst != (cnt == 0)) err_model = 1'b1;
        done = lst || (cnt == 0);
        p = p + AW'(1);
        cnt--;
        k++;
      end
    end
    @(posedge clk); #1;
    wr_valid = 1'b0; wr_last = 1'b0;
    @(negedge clk);
    check("wr_burst_end", {wr_ready, wr_req_ready}, 2'b01);
    check("wr_err", wr_err, err_model);
  endtask

  // ---------------- main sequence ----------------
  int          op, sel, last_at;
  logic [4:0]  rlen;
  logic [31:0] raddr;

  initial begin
    rst = 1'b1;
    rd_req_addr = '0; rd_req_len = '0; rd_req_valid = 1'b0;
    wr_req_addr = '0; wr_req_len = '0; wr_req_valid = 1'b0;
    wr_data = '0; wr_valid = 1'b0; wr_last = 1'b0;
    dbg_wen = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    dir_ready = 1'b1; rdy_rand = 1'b0; err_model = 1'b0;
    l_rd_req_addr = '0; l_rd_req_len = '0; l_rd_req_valid = 1'b0; l_rd_ready = 1'b0;
    l_wr_req_addr = '0; l_wr_req_len = '0; l_wr_req_valid = 1'b0;
    l_wr_data = '0; l_wr_valid = 1'b0; l_wr_last = 1'b0;
    l_dbg_wen = 1'b0; l_dbg_addr = '0; l_dbg_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {rd_req_ready, wr_req_ready, rd_valid, rd_last, wr_ready, wr_err},
          6'b110000);
    check("reset_rdata", rd_rdata, 0);
    check("reset_state_lat", {l_rd_req_ready, l_wr_req_ready, l_rd_valid, l_wr_ready, l_wr_err},
          5'b11000);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int w = 0; w < DEPTH; w++) dbg_write(AW'(w), $urandom);

    // directed read: preloaded 0x11..0x44, full-rate beats, ready returns at T+5
    dbg_write(0, 32'h11); dbg_write(1, 32'h22); dbg_write(2, 32'h33); dbg_write(3, 32'h44);
    do_read(32'h0, 5'd3);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("rd_burst_timing", {rd_valid, rd_req_ready, rd_last}, {2'b10, (k == 4)});
    end
    @(negedge clk);
    check("rd_req_ready_T5", {rd_valid, rd_req_ready}, 2'b01);
    check("rd_burst_drained", exp_q.size(), 0);

    // read latency 3, single beat, stalled then accepted
    @(posedge clk); #1;
    l_dbg_wen = 1'b1; l_dbg_addr = 4; l_dbg_wdata = 32'hC0DE_0004;
    @(posedge clk); #1;
    l_dbg_wen = 1'b0;
    l_rd_req_addr = 32'h10; l_rd_req_len = 5'd0; l_rd_req_valid = 1'b1; l_rd_ready = 1'b0;
    @(negedge clk);
    check("lat_req_ready", l_rd_req_ready, 1);
    check("lat_dbg_rdata", l_dbg_rdata, 32'hC0DE_0004);
    @(posedge clk); #1;
    l_rd_req_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("lat_wait", {l_rd_valid, l_rd_req_ready, l_rd_rdata}, '0);
    end
    @(negedge clk);
    check("lat_first_beat", {l_rd_valid, l_rd_last, l_rd_rdata}, {2'b11, 32'hC0DE_0004});
    @(negedge clk);
    check("lat_stall_hold", {l_rd_valid, l_rd_last, l_rd_rdata}, {2'b11, 32'hC0DE_0004});
    @(posedge clk); #1;
    l_rd_ready = 1'b1;
    @(negedge clk);
    check("lat_accept_beat", {l_rd_valid, l_rd_last, l_rd_rdata}, {2'b11, 32'hC0DE_0004});
    @(negedge clk);
    check("lat_done", {l_rd_valid, l_rd_last, l_rd_req_ready, l_rd_rdata}, {3'b001, 32'h0});

    // write 0xA0..0xA7 to words 8..15 with bubbles
    do_write(32'h20, 5'd7, 7, 1'b1, 32'hA0, 2);
    for (int w = 8; w < 16; w++) begin
      dbg_addr = AW'(w); #1;
      check("wr_seq_word", dbg_rdata, 32'hA0 + (w - 8));
    end

    // wrapping write then read back the same range
    do_write(32'hFF8, 5'd3, 3, 1'b1, 32'hB0, 1);
    dbg_addr = 1022; #1; check("wrap_word_1022", dbg_rdata, 32'hB0);
    dbg_addr = 1023; #1; check("wrap_word_1023", dbg_rdata, 32'hB1);
    dbg_addr = 0;    #1; check("wrap_word_0", dbg_rdata, 32'hB2);
    dbg_addr = 1;    #1; check("wrap_word_1", dbg_rdata, 32'hB3);
    do_read(32'hFF8, 5'd3);
    wait_read_done();

    // early last, then missing last; wr_err sticky
    do_write(32'h100, 5'd3, 1, 1'b0, 0, 1);
    check("early_last_err", wr_err, 1);
    do_write(32'h200, 5'd1, -1, 1'b0, 0, 1);
    check("missing_last_err_sticky", wr_err, 1);

    // concurrent read beat, write beat and debug write on word 100
    wr_request(32'd400, 5'd0);
    do_read(32'd400, 5'd0);
    wr_valid = 1'b1; wr_data = 32'h5A5A_0100; wr_last = 1'b1;
    dbg_wen = 1'b1; dbg_addr = 100; dbg_wdata = 32'hDB00_0100;
    @(negedge clk);
    check("collide_wr_ready", wr_ready, 1);
    @(posedge clk); #1;
    wr_valid = 1'b0; wr_last = 1'b0; dbg_wen = 1'b0;
    model_mem[100] = 32'h5A5A_0100;
    @(negedge clk);
    check("collide_wr_wins", dbg_rdata, 32'h5A5A_0100);
    check("collide_channels_idle", {wr_ready, wr_req_ready, rd_valid, rd_req_ready}, 4'b0101);
    check("collide_read_drained", exp_q.size(), 0);

    // randomized mix
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        raddr = $urandom; rlen = 5'($urandom_range(0, 31));
        rdy_rand = 1'b1;
        do_read(raddr, rlen);
        wait_read_done();
        rdy_rand = 1'b0;
      end else if (op == 1) begin
        raddr = $urandom; rlen = 5'($urandom_range(0, 31));
        sel = $urandom_range(0, 5);
        last_at = (sel == 0) ? $urandom_range(0, int'(rlen)) : (sel == 1) ? -1 : int'(rlen);
        do_write(raddr, rlen, last_at, 1'b0, 0, 2);
      end else begin
        dbg_write(AW'($urandom_range(0, DEPTH - 1)), $urandom);
      end
    end

    // reset in the middle of a read burst
    dir_ready = 1'b1;
    do_read(32'h800, 5'd15);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    err_model = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_read_reset", {rd_valid, rd_last, rd_req_ready, wr_req_ready, wr_ready, wr_err},
          6'b001100);
    check("mid_read_reset_rdata", rd_rdata, 0);

    // whole RAM against the model
    for (int w = 0; w < DEPTH; w++) begin
      dbg_addr = AW'(w); #1;
      check("final_mem", {AW'(w), dbg_rdata}, {AW'(w), model_mem[w]});
    end
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
